// File: rtl/updn_cmd_ctrl.sv
// Button front-end for the 5-bit up/down counter: sync, debounce,
// auto-repeat and limit masking into one-cycle Cmd_* pulses.
module updn_cmd_ctrl #(
  parameter int WIDTH        = 5,
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Btn_Up,
  input  logic             Btn_Dn,
  input  logic             Btn_Load,
  input  logic [WIDTH-1:0] Sw_In,
  input  logic             High,
  input  logic             Low,
  output logic             Cmd_Up,
  output logic             Cmd_Down,
  output logic             Cmd_Load,
  output logic [WIDTH-1:0] Cmd_In
);

  localparam int CW   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);

  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_LD = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_REPEAT
  } state_t;

  logic [2:0]       w_btn;
  logic [2:0]       w_press;
  logic             w_dir_lvl;

  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [WIDTH-1:0] r_sw1;
  logic [WIDTH-1:0] r_sw2;
  logic [2:0]       r_db;
  logic [2:0]       r_dbq;
  logic [CW-1:0]    r_cnt [3];

  state_t           r_state;
  logic             r_dir;
  logic [TW-1:0]    r_tmr;

  assign w_btn   = {Btn_Load, Btn_Dn, Btn_Up};
  assign w_press = r_db & ~r_dbq;
  // r_dir = 1 means the hold being tracked is Down
  assign w_dir_lvl = r_dir ? r_db[B_DN] : r_db[B_UP];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_sw1 <= '0;
      r_sw2 <= '0;
    end else begin
      r_s1  <= w_btn;
      r_s2  <= r_s1;
      r_sw1 <= Sw_In;
      r_sw2 <= r_sw1;
    end
  end

  // Count consecutive samples that disagree with the accepted level
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db  <= '0;
      r_dbq <= '0;
      for (int i = 0; i < 3; i++)
        r_cnt[i] <= '0;
    end else begin
      r_dbq <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_tmr    <= '0;
      Cmd_Up   <= 1'b0;
      Cmd_Down <= 1'b0;
      Cmd_Load <= 1'b0;
      Cmd_In   <= '0;
    end else begin
      Cmd_Up   <= 1'b0;
      Cmd_Down <= 1'b0;
      Cmd_Load <= 1'b0;
      if (w_press[B_LD]) begin
        Cmd_Load <= 1'b1;
        Cmd_In   <= r_sw2;
        r_state  <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_press[B_DN]) begin
              Cmd_Down <= ~Low;
              r_dir    <= 1'b1;
              r_tmr    <= TW'(REPEAT_DELAY - 1);
              r_state  <= S_FIRST;
            end else if (w_press[B_UP]) begin
              Cmd_Up   <= ~High;
              r_dir    <= 1'b0;
              r_tmr    <= TW'(REPEAT_DELAY - 1);
              r_state  <= S_FIRST;
            end
          end
          S_FIRST, S_REPEAT: begin
            if (!w_dir_lvl) begin
              r_state <= S_IDLE;
            end else if (r_tmr == '0) begin
              if (r_dir)
                Cmd_Down <= ~Low;
              else
                Cmd_Up   <= ~High;
              r_tmr   <= TW'(REPEAT_RATE - 1);
              r_state <= S_REPEAT;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updn_cmd_ctrl.sv
// Directed bench for updn_cmd_ctrl: reset, bounce, repeat,
// load, priority, limits and async reset mid-hold.
module tb_updn_cmd_ctrl;

  logic       CLK;
  logic       RST;
  logic       Btn_Up;
  logic       Btn_Dn;
  logic       Btn_Load;
  logic [4:0] Sw_In;
  logic       High;
  logic       Low;
  logic       Cmd_Up;
  logic       Cmd_Down;
  logic       Cmd_Load;
  logic [4:0] Cmd_In;

  int n_chk = 0;
  int n_err = 0;
  int nu, nd, nl;
  int nmulti = 0;

  updn_cmd_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .Btn_Up   (Btn_Up),
    .Btn_Dn   (Btn_Dn),
    .Btn_Load (Btn_Load),
    .Sw_In    (Sw_In),
    .High     (High),
    .Low      (Low),
    .Cmd_Up   (Cmd_Up),
    .Cmd_Down (Cmd_Down),
    .Cmd_Load (Cmd_Load),
    .Cmd_In   (Cmd_In)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nu = 0;
    nd = 0;
    nl = 0;
  endtask

  // Advance n falling edges, tallying pulses seen at each one
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      nu += int'(Cmd_Up);
      nd += int'(Cmd_Down);
      nl += int'(Cmd_Load);
      if (int'(Cmd_Up) + int'(Cmd_Down) + int'(Cmd_Load) > 1)
        nmulti++;
    end
  endtask

  task automatic settle();
    Btn_Up   = 1'b0;
    Btn_Dn   = 1'b0;
    Btn_Load = 1'b0;
    run(12);
  endtask

  initial begin
    RST      = 1'b1;
    Btn_Up   = 1'b1;
    Btn_Dn   = 1'b0;
    Btn_Load = 1'b0;
    Sw_In    = 5'd0;
    High     = 1'b0;
    Low      = 1'b0;

    // T1 reset with Up held
    clr();
    run(4);
    chk("rst_up", int'(Cmd_Up), 0);
    chk("rst_dn", int'(Cmd_Down), 0);
    chk("rst_ld", int'(Cmd_Load), 0);
    chk("rst_in", int'(Cmd_In), 0);
    chk("rst_cnt", nu + nd + nl, 0);
    RST = 1'b0;
    clr();
    run(6);
    chk("t1_early", nu, 0);
    run(1);
    chk("t1_up_e6", int'(Cmd_Up), 1);
    run(1);
    chk("t1_up_1cyc", int'(Cmd_Up), 0);
    clr();
    settle();
    chk("t1_norpt", nu, 0);

    // T2 bounce
    clr();
    Btn_Up = 1'b1; run(2);
    Btn_Up = 1'b0; run(2);
    Btn_Up = 1'b1; run(2);
    Btn_Up = 1'b0; run(2);
    Btn_Up = 1'b1;
    run(6);
    chk("t2_bounce", nu, 0);
    run(1);
    chk("t2_up", int'(Cmd_Up), 1);
    clr();
    settle();
    chk("t2_once", nu, 0);

    // T3 auto-repeat on Down
    clr();
    Btn_Dn = 1'b1;
    run(6);
    chk("t3_early", nd, 0);
    run(1);
    chk("t3_t0", int'(Cmd_Down), 1);
    clr();
    run(15);
    chk("t3_gap16", nd, 0);
    run(1);
    chk("t3_t16", int'(Cmd_Down), 1);
    clr();
    run(3);
    chk("t3_gap4a", nd, 0);
    run(1);
    chk("t3_t20", int'(Cmd_Down), 1);
    clr();
    run(3);
    chk("t3_gap4b", nd, 0);
    run(1);
    chk("t3_t24", int'(Cmd_Down), 1);
    clr();
    run(29);
    chk("t3_rate", nd, 7);
    Btn_Dn = 1'b0;
    clr();
    run(20);
    chk("t3_release", nd, 1);

    // T4 load
    clr();
    Sw_In    = 5'd13;
    Btn_Load = 1'b1;
    run(6);
    chk("t4_early", nl, 0);
    run(1);
    chk("t4_load", int'(Cmd_Load), 1);
    chk("t4_in13", int'(Cmd_In), 13);
    Sw_In = 5'd3;
    clr();
    run(20);
    chk("t4_norpt", nl, 0);
    chk("t4_hold13", int'(Cmd_In), 13);
    settle();
    chk("t4_still13", int'(Cmd_In), 13);

    // T5 Up+Down together, Down wins
    clr();
    Btn_Up = 1'b1;
    Btn_Dn = 1'b1;
    run(6);
    chk("t5_early", nu + nd, 0);
    run(1);
    chk("t5_dn", int'(Cmd_Down), 1);
    chk("t5_noup", int'(Cmd_Up), 0);
    clr();
    settle();
    chk("t5_after", nu + nd, 0);

    // T5 Load aborts an Up hold
    clr();
    Btn_Up = 1'b1;
    run(6);
    run(1);
    chk("t5_up", int'(Cmd_Up), 1);
    Btn_Load = 1'b1;
    clr();
    run(6);
    chk("t5_ld_early", nl + nu, 0);
    run(1);
    chk("t5_ld", int'(Cmd_Load), 1);
    chk("t5_ld_noup", int'(Cmd_Up), 0);
    chk("t5_in3", int'(Cmd_In), 3);
    Btn_Load = 1'b0;
    clr();
    run(30);
    chk("t5_abort", nu, 0);
    settle();
    clr();
    Btn_Up = 1'b1;
    run(6);
    run(1);
    chk("t5_repress", int'(Cmd_Up), 1);
    settle();

    // T6 High masks Up until dropped
    clr();
    High   = 1'b1;
    Btn_Up = 1'b1;
    run(7);
    chk("t6_hi_t0", nu, 0);
    run(16);
    chk("t6_hi_t16", nu, 0);
    High = 1'b0;
    run(3);
    chk("t6_hi_gap", nu, 0);
    run(1);
    chk("t6_hi_t20", int'(Cmd_Up), 1);
    settle();

    // T6 Low masks Down until dropped
    clr();
    Low    = 1'b1;
    Btn_Dn = 1'b1;
    run(7);
    chk("t6_lo_t0", nd, 0);
    run(16);
    chk("t6_lo_t16", nd, 0);
    Low = 1'b0;
    run(3);
    chk("t6_lo_gap", nd, 0);
    run(1);
    chk("t6_lo_t20", int'(Cmd_Down), 1);
    settle();

    // Async reset mid-hold, then re-press from scratch
    clr();
    Btn_Up = 1'b1;
    run(7);
    chk("t7_up", int'(Cmd_Up), 1);
    RST = 1'b1;
    #1;
    chk("t7_async_up", int'(Cmd_Up), 0);
    chk("t7_async_in", int'(Cmd_In), 0);
    @(negedge CLK);
    RST = 1'b0;
    clr();
    run(6);
    chk("t7_early", nu, 0);
    run(1);
    chk("t7_repress", int'(Cmd_Up), 1);
    settle();

    chk("onehot", nmulti, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
